mem_wb: RTL and testbench

MEM_WB -- requirements
Module: mem_wb

---
 rtl/mem_wb.sv | 125 ++++++++++++
 tb/tb_mem_wb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb.sv
// MEM/WB pipeline stage. It registers the memory-stage results and extracts and extends load data.
// It also flags misaligned loads and counts retired instructions.
module mem_wb #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             I_stall,
  input  logic             I_flush,
  input  logic             W_MEM_valid,
  input  logic [31:0]      W_MEM_mem_data,
  input  logic [31:0]      W_MEM_alu_res,
  input  logic [4:0]       W_MEM_rd,
  input  logic             W_MEM_w_reg_ena,
  input  logic             W_MEM_wb_sel,
  input  logic [2:0]       W_MEM_load_type,
  output logic             W_WB_w_reg_ena,
  output logic [4:0]       W_WB_rd,
  output logic [31:0]      W_WB_w_data,
  output logic             W_WB_valid,
  output logic             W_WB_misalign,
  output logic             W_WB_err_sticky,
  output logic [CNT_W-1:0] W_WB_retired
);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  // The same rule is applied to incoming fields (for the sticky/counter update) and to registered fields.
  function automatic logic is_misaligned(input logic wb_sel, input logic [2:0] load_type,
                                         input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (wb_sel) begin
      case (load_type)
        LT_LB, LT_LBU: mis = 1'b0;
        LT_LH, LT_LHU: mis = off[0];
        default:       mis = (off != 2'd0);
      endcase
    end
    return mis;
  endfunction

  logic             valid_reg;
  logic [31:0]      mem_data_reg;
  logic [31:0]      alu_res_reg;
  logic [4:0]       rd_reg;
  logic             w_reg_ena_reg;
  logic             wb_sel_reg;
  logic [2:0]       load_type_reg;
  logic             err_sticky_reg;
  logic [CNT_W-1:0] retired_reg;

  logic             capture_mis;

  assign capture_mis = is_misaligned(W_MEM_wb_sel, W_MEM_load_type, W_MEM_alu_res[1:0]);

  // Resetting every field to zero also forces W_WB_w_data to zero, because wb_sel=0 selects alu_res.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      mem_data_reg   <= '0;
      alu_res_reg    <= '0;
      rd_reg         <= '0;
      w_reg_ena_reg  <= 1'b0;
      wb_sel_reg     <= 1'b0;
      load_type_reg  <= '0;
      err_sticky_reg <= 1'b0;
      retired_reg    <= '0;
    end else if (I_flush) begin
      valid_reg <= 1'b0;
    end else if (!I_stall) begin
      valid_reg     <= W_MEM_valid;
      mem_data_reg  <= W_MEM_mem_data;
      alu_res_reg   <= W_MEM_alu_res;
      rd_reg        <= W_MEM_rd;
      w_reg_ena_reg <= W_MEM_w_reg_ena;
      wb_sel_reg    <= W_MEM_wb_sel;
      load_type_reg <= W_MEM_load_type;
      if (W_MEM_valid) begin
        if (capture_mis) err_sticky_reg <= 1'b1;
        else             retired_reg    <= retired_reg + 1'b1;
      end
    end
  end

  logic [1:0]  off;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;
  logic        mis_now;

  always_comb begin
    off      = alu_res_reg[1:0];
    byte_val = mem_data_reg[7:0];
    case (off)
      2'd0: byte_val = mem_data_reg[7:0];
      2'd1: byte_val = mem_data_reg[15:8];
      2'd2: byte_val = mem_data_reg[23:16];
      2'd3: byte_val = mem_data_reg[31:24];
      default: byte_val = mem_data_reg[7:0];
    endcase
    half_val  = off[1] ? mem_data_reg[31:16] : mem_data_reg[15:0];
    load_data = mem_data_reg;
    case (load_type_reg)
      LT_LB:   load_data = {{24{byte_val[7]}}, byte_val};
      LT_LBU:  load_data = {24'd0, byte_val};
      LT_LH:   load_data = {{16{half_val[15]}}, half_val};
      LT_LHU:  load_data = {16'd0, half_val};
      default: load_data = mem_data_reg;
    endcase
    mis_now = is_misaligned(wb_sel_reg, load_type_reg, off);
  end

  assign W_WB_valid      = valid_reg;
  assign W_WB_rd         = rd_reg;
  assign W_WB_w_data     = wb_sel_reg ? load_data : alu_res_reg;
  assign W_WB_misalign   = valid_reg & mis_now;
  assign W_WB_w_reg_ena  = valid_reg & w_reg_ena_reg & (rd_reg != 5'd0) & ~mis_now;
  assign W_WB_err_sticky = err_sticky_reg;
  assign W_WB_retired    = retired_reg;

endmodule

// File: tb/tb_mem_wb.sv
// Testbench for mem_wb. It runs directed and random transactions against a load-semantics reference model.
// The counter width is reduced so that the wrap-around case stays short.
module tb_mem_wb;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             I_stall, I_flush;
  logic             W_MEM_valid;
  logic [31:0]      W_MEM_mem_data, W_MEM_alu_res;
  logic [4:0]       W_MEM_rd;
  logic             W_MEM_w_reg_ena, W_MEM_wb_sel;
  logic [2:0]       W_MEM_load_type;
  logic             W_WB_w_reg_ena;
  logic [4:0]       W_WB_rd;
  logic [31:0]      W_WB_w_data;
  logic             W_WB_valid, W_WB_misalign, W_WB_err_sticky;
  logic [CNT_W-1:0] W_WB_retired;

  mem_wb #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .I_stall(I_stall), .I_flush(I_flush),
    .W_MEM_valid(W_MEM_valid), .W_MEM_mem_data(W_MEM_mem_data),
    .W_MEM_alu_res(W_MEM_alu_res), .W_MEM_rd(W_MEM_rd),
    .W_MEM_w_reg_ena(W_MEM_w_reg_ena), .W_MEM_wb_sel(W_MEM_wb_sel),
    .W_MEM_load_type(W_MEM_load_type), .W_WB_w_reg_ena(W_WB_w_reg_ena),
    .W_WB_rd(W_WB_rd), .W_WB_w_data(W_WB_w_data), .W_WB_valid(W_WB_valid),
    .W_WB_misalign(W_WB_misalign), .W_WB_err_sticky(W_WB_err_sticky),
    .W_WB_retired(W_WB_retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the instruction currently held by the stage, plus architectural counters.
  logic        m_valid;
  logic [31:0] m_mem, m_alu;
  logic [4:0]  m_rd;
  logic        m_we, m_sel;
  logic [2:0]  m_lt;
  logic        exp_err;
  int          exp_ret;

  function automatic int access_size(input logic [2:0] lt);
    if (lt == 3'd1 || lt == 3'd2) return 1;
    if (lt == 3'd3 || lt == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic ref_mis(input logic sel, input logic [2:0] lt, input logic [31:0] addr);
    return sel && ((addr % access_size(lt)) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [2:0] lt,
                                           input logic [31:0] addr);
    int sz;
    int lane;
    logic [31:0] v;
    sz   = access_size(lt);
    if (sz == 4) return mem;
    lane = int'(addr % 4) / sz * sz;
    v    = (mem >> (8 * lane)) & ((32'd1 << (8 * sz)) - 32'd1);
    if ((lt == 3'd1 || lt == 3'd3) && v >= (32'd1 << (8 * sz - 1)))
      v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] mem, input logic [31:0] alu,
                        input logic [4:0] rd, input logic we, input logic sel, input logic [2:0] lt);
    W_MEM_valid = v; W_MEM_mem_data = mem; W_MEM_alu_res = alu; W_MEM_rd = rd;
    W_MEM_w_reg_ena = we; W_MEM_wb_sel = sel; W_MEM_load_type = lt;
  endtask

  task automatic model_reset();
    m_valid = 0; m_mem = 0; m_alu = 0; m_rd = 0; m_we = 0; m_sel = 0; m_lt = 0;
    exp_err = 0; exp_ret = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic mis;
    mis = m_valid && ref_mis(m_sel, m_lt, m_alu);
    chk({tag, ".valid"}, {31'd0, W_WB_valid}, {31'd0, m_valid});
    chk({tag, ".misalign"}, {31'd0, W_WB_misalign}, {31'd0, mis});
    chk({tag, ".we"}, {31'd0, W_WB_w_reg_ena}, {31'd0, m_valid && m_we && m_rd != 0 && !mis});
    chk({tag, ".err"}, {31'd0, W_WB_err_sticky}, {31'd0, exp_err});
    chk({tag, ".retired"}, {28'd0, W_WB_retired}, 32'(exp_ret % (1 << CNT_W)));
    if (m_valid) begin
      chk({tag, ".rd"}, {27'd0, W_WB_rd}, {27'd0, m_rd});
      chk({tag, ".wdata"}, W_WB_w_data, m_sel ? ref_load(m_mem, m_lt, m_alu) : m_alu);
    end
  endtask

  // One rising edge: advance the model with the inputs the DUT just sampled, then compare.
  task automatic tick(input string tag);
    @(posedge clk); #1;
    if (I_flush) m_valid = 0;
    else if (!I_stall) begin
      m_valid = W_MEM_valid; m_mem = W_MEM_mem_data; m_alu = W_MEM_alu_res; m_rd = W_MEM_rd;
      m_we = W_MEM_w_reg_ena; m_sel = W_MEM_wb_sel; m_lt = W_MEM_load_type;
      if (W_MEM_valid) begin
        if (ref_mis(W_MEM_wb_sel, W_MEM_load_type, W_MEM_alu_res)) exp_err = 1;
        else exp_ret++;
      end
    end
    check_outputs(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, W_WB_valid}, 32'd0);
    chk({tag, ".we"}, {31'd0, W_WB_w_reg_ena}, 32'd0);
    chk({tag, ".misalign"}, {31'd0, W_WB_misalign}, 32'd0);
    chk({tag, ".err"}, {31'd0, W_WB_err_sticky}, 32'd0);
    chk({tag, ".retired"}, {28'd0, W_WB_retired}, 32'd0);
    chk({tag, ".rd"}, {27'd0, W_WB_rd}, 32'd0);
    chk({tag, ".wdata"}, W_WB_w_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CNT_W-1:0] frozen_ret;
    rst_n = 0; I_stall = 0; I_flush = 0;
    set_in(1, 32'h1234_5678, 32'h0, 5'd1, 1, 0, 3'd0);
    model_reset();
    #2 check_zero("reset");
    @(posedge clk); #1 rst_n = 1;

    // Aligned LW
    set_in(1, 32'hDEADBEEF, 32'h100, 5'd5, 1, 1, 3'd0);
    tick("lw");
    chk("lw.wdata_const", W_WB_w_data, 32'hDEADBEEF);
    chk("lw.retired_const", {28'd0, W_WB_retired}, 32'd1);

    // Byte/halfword extraction
    set_in(1, 32'h80FF7F01, 32'h103, 5'd6, 1, 1, 3'd1); tick("lb3");
    chk("lb3.const", W_WB_w_data, 32'hFFFFFF80);
    set_in(1, 32'h80FF7F01, 32'h103, 5'd6, 1, 1, 3'd2); tick("lbu3");
    chk("lbu3.const", W_WB_w_data, 32'h00000080);
    set_in(1, 32'h80FF7F01, 32'h102, 5'd6, 1, 1, 3'd3); tick("lh2");
    chk("lh2.const", W_WB_w_data, 32'hFFFF80FF);
    set_in(1, 32'h80FF7F01, 32'h100, 5'd6, 1, 1, 3'd4); tick("lhu0");
    chk("lhu0.const", W_WB_w_data, 32'h00007F01);

    // Misaligned LW, then aligned LW
    set_in(1, 32'hCAFEF00D, 32'h102, 5'd7, 1, 1, 3'd0); tick("lw_mis");
    chk("lw_mis.misalign_const", {31'd0, W_WB_misalign}, 32'd1);
    chk("lw_mis.retired_const", {28'd0, W_WB_retired}, 32'd5);
    set_in(1, 32'hCAFEF00D, 32'h104, 5'd7, 1, 1, 3'd0); tick("lw_after");
    chk("lw_after.err_const", {31'd0, W_WB_err_sticky}, 32'd1);

    // ALU op to x0
    set_in(1, 32'h0, 32'h55, 5'd0, 1, 0, 3'd0); tick("alu_x0");
    chk("alu_x0.we_const", {31'd0, W_WB_w_reg_ena}, 32'd0);

    // Stall three edges with changing inputs
    frozen_ret = W_WB_retired;
    I_stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, $urandom, $urandom, 5'($urandom), 1, 1'($urandom), 3'($urandom));
      tick("stall");
    end
    chk("stall.retired_frozen", {28'd0, W_WB_retired}, {28'd0, frozen_ret});

    // Stall and flush together
    I_flush = 1;
    set_in(1, 32'h1, 32'h8, 5'd3, 1, 0, 3'd0); tick("stall_flush");
    I_stall = 0; I_flush = 0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      I_stall = ($urandom % 8) == 0;
      I_flush = ($urandom % 10) == 0;
      set_in(($urandom % 4) != 0, $urandom, $urandom, 5'($urandom), 1'($urandom),
             1'($urandom), 3'($urandom));
      tick("rand");
    end

    // Async reset between edges, asserted while stalled and flushed
    I_stall = 1; I_flush = 1;
    rst_n = 0; model_reset();
    #1 check_zero("async_reset");
    #2 rst_n = 1; I_stall = 0; I_flush = 0;

    // Counter wrap: reach 2^CNT_W-1, then one more retire
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      set_in(1, 32'h0, 32'(i), 5'd9, 1, 0, 3'd0);
      tick("fill");
    end
    chk("wrap.pre_const", {28'd0, W_WB_retired}, 32'd15);
    set_in(1, 32'h0, 32'h77, 5'd9, 1, 0, 3'd0); tick("wrap");
    chk("wrap.zero_const", {28'd0, W_WB_retired}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
